// File: rtl/bias_buf_pkg.sv
// Shared definitions for the bias buffer and its loader: FSM state encoding
// and the bank-count derivation both sides must agree on.
package bias_buf_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_LOAD  = 2'd1;
    localparam logic [1:0] STATE_FLUSH = 2'd2;
    localparam logic [1:0] STATE_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_LOAD  = STATE_LOAD,
        ST_FLUSH = STATE_FLUSH,
        ST_DONE  = STATE_DONE
    } state_t;

    // One bank word per stream beat; a group of X_PE signed bytes spans the banks.
    function automatic int calc_buffer_num(input int x_pe, input int data_len);
        return (8 * x_pe) / data_len;
    endfunction

endpackage

// File: rtl/bias_byteswap.sv
// Combinational byte reversal of a DATA_LEN-bit word (big-endian DDR packing).
module bias_byteswap #(
    parameter int DATA_LEN = 64
) (
    input  logic [DATA_LEN-1:0] din,
    output logic [DATA_LEN-1:0] dout
);

    localparam int NBYTES = DATA_LEN / 8;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign dout[8*gi +: 8] = din[8*(NBYTES-1-gi) +: 8];
        end
    endgenerate

endmodule

// File: rtl/bias_loader.sv
// Bias buffer write-side feeder: packs BUFFER_NUM stream beats per buffer address.
// Define BIAS_LOADER_BYTESWAP_EN to byte-reverse each beat before it is written.
module bias_loader
    import bias_buf_pkg::*;
#(
    parameter int X_PE       = 16,
    parameter int ADDR_LEN   = 9,
    parameter int DATA_LEN   = 64,
    parameter int BUFFER_NUM = calc_buffer_num(X_PE, DATA_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_conf,
    input  logic [ADDR_LEN-1:0]   st_wr_addr,
    input  logic [ADDR_LEN:0]     ld_groups,
    input  logic                  ld_abort,
    input  logic [DATA_LEN-1:0]   s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_LEN-1:0]   data_wr,
    output logic [ADDR_LEN-1:0]   wr_addr,
    output logic [BUFFER_NUM-1:0] wr_en,
    output logic                  done,
    output logic                  idle
);

    localparam int BANK_W = (BUFFER_NUM > 1) ? $clog2(BUFFER_NUM) : 1;
    localparam int CNT_W  = ADDR_LEN + 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BUFFER_NUM - 1);

    state_t              state_reg, state_next;
    logic [ADDR_LEN-1:0] ptr_reg, ptr_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [BANK_W-1:0]   bank_reg, bank_next;
    logic                wr_fire;
    logic [BUFFER_NUM-1:0] bank_sel;
    logic [DATA_LEN-1:0] beat_data;

`ifdef BIAS_LOADER_BYTESWAP_EN
    bias_byteswap #(
        .DATA_LEN (DATA_LEN)
    ) u_byteswap (
        .din  (s_data),
        .dout (beat_data)
    );
`else
    assign beat_data = s_data;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < BUFFER_NUM; gi++) begin : g_bank_sel
            assign bank_sel[gi] = (bank_reg == BANK_W'(gi));
        end
    endgenerate

    assign s_ready = (state_reg == ST_LOAD);
    assign done    = (state_reg == ST_DONE);
    assign idle    = (state_reg == ST_IDLE);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        bank_next  = bank_reg;
        wr_fire    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ld_conf && !ld_abort) begin
                    ptr_next   = st_wr_addr;
                    cnt_next   = ld_groups;
                    bank_next  = '0;
                    state_next = (ld_groups != '0) ? ST_LOAD : ST_FLUSH;
                end
            end
            ST_LOAD: begin
                if (ld_abort) begin
                    state_next = ST_IDLE;
                end else if (s_valid) begin
                    wr_fire = 1'b1;
                    if (bank_reg == LAST_BANK) begin
                        // Group complete: advance address (wraps at the buffer top).
                        bank_next = '0;
                        ptr_next  = ptr_reg + ADDR_LEN'(1);
                        cnt_next  = cnt_reg - CNT_W'(1);
                        if (cnt_reg == CNT_W'(1)) begin
                            state_next = ST_FLUSH;
                        end
                    end else begin
                        bank_next = bank_reg + BANK_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                state_next = ld_abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            bank_reg  <= '0;
            data_wr   <= '0;
            wr_addr   <= '0;
            wr_en     <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            bank_reg  <= bank_next;
            wr_en     <= wr_fire ? bank_sel : '0;
            if (wr_fire) begin
                data_wr <= beat_data;
                wr_addr <= ptr_reg;
            end
        end
    end

endmodule

// File: tb/tb_bias_loader.sv
// Randomized self-checking bench for bias_loader against a write-list reference model.
module tb_bias_loader;

    localparam int BN    = 2;
    localparam int DEPTH = 512;

    logic        clk;
    logic        rst_n;
    logic        ld_conf;
    logic [8:0]  st_wr_addr;
    logic [9:0]  ld_groups;
    logic        ld_abort;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] data_wr;
    logic [8:0]  wr_addr;
    logic [1:0]  wr_en;
    logic        done;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] exp_data[$];
    int          exp_addr[$];
    int          exp_en[$];
    int          n_wr;
    int          last_wr_cyc;

    bias_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_conf    (ld_conf),
        .st_wr_addr (st_wr_addr),
        .ld_groups  (ld_groups),
        .ld_abort   (ld_abort),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .data_wr    (data_wr),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .done       (done),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_data(input logic [63:0] b);
        logic [63:0] r;
        r = b;
`ifdef BIAS_LOADER_BYTESWAP_EN
        for (int i = 0; i < 8; i++) r[8*i +: 8] = b[8*(7-i) +: 8];
`endif
        return r;
    endfunction

    task automatic sample_writes();
        if (wr_en != 2'b00) begin
            if (exp_en.size() == 0) begin
                chk("extra_wr", {62'd0, wr_en}, 64'd0);
            end else begin
                chk("wr_en",   {62'd0, wr_en},   64'(exp_en.pop_front()));
                chk("wr_addr", {55'd0, wr_addr}, 64'(exp_addr.pop_front()));
                chk("data_wr", data_wr,          exp_data.pop_front());
            end
            n_wr++;
            last_wr_cyc = cyc;
        end
    endtask

    // vmode: 0 always valid, 1 random valid + stray ld_conf, 2 fixed gap pattern.
    // bmode: 0 random beats, 1 counting beats 1..N, 2 first beat 0x0102030405060708.
    task automatic run_load(input int start, input int groups, input int vmode,
                            input int bmode, input int abort_at, input int reset_at);
        int total;
        int accepted;
        int vidx;
        int budget;
        int done_cnt;
        int done_cyc;
        int conf_cyc;
        int abort_cyc;
        int n_exp;
        bit finished;
        logic [63:0] beats[$];
        logic [63:0] b;
        bit pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        total = groups * BN;
        accepted = 0; vidx = 0; done_cnt = 0; done_cyc = -1; abort_cyc = -1;
        finished = 0; n_wr = 0; last_wr_cyc = -1;
        exp_data.delete(); exp_addr.delete(); exp_en.delete();

        for (int k = 0; k < total; k++) begin
            if (bmode == 1)                b = 64'(k + 1);
            else if (bmode == 2 && k == 0) b = 64'h0102030405060708;
            else                           b = {$urandom, $urandom};
            beats.push_back(b);
            exp_en.push_back(1 << (k % BN));
            exp_addr.push_back((start + k / BN) % DEPTH);
            exp_data.push_back(model_data(b));
        end
        n_exp = (abort_at > 0) ? abort_at : ((reset_at > 0) ? reset_at : total);

        ld_conf = 1'b1; st_wr_addr = 9'(start); ld_groups = 10'(groups);
        ld_abort = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("idle_before", {63'd0, idle}, 64'd1);
        conf_cyc = cyc;
        @(posedge clk); #1;

        budget = total * 8 + 40;
        while (!finished && budget > 0) begin
            budget--;
            if (reset_at > 0 && accepted == reset_at) begin
                sample_writes();
                rst_n = 1'b0;
                #1;
                chk("rst_wr_en", {62'd0, wr_en},   64'd0);
                chk("rst_idle",  {63'd0, idle},    64'd1);
                chk("rst_ready", {63'd0, s_ready}, 64'd0);
                #2;
                rst_n = 1'b1;
                finished = 1;
                @(posedge clk); #1;
            end else begin
                ld_abort = (abort_at > 0 && accepted == abort_at && abort_cyc < 0);
                ld_conf  = (vmode == 1) && (done_cnt == 0) && ($urandom_range(0, 7) == 0);
                st_wr_addr = 9'($urandom);
                ld_groups  = 10'($urandom);
                if (ld_abort || accepted >= total) s_valid = 1'b0;
                else if (vmode == 0)               s_valid = 1'b1;
                else if (vmode == 1)               s_valid = 1'($urandom_range(0, 1));
                else                               s_valid = (vidx < 7) ? pat[vidx] : 1'b1;
                s_data = (accepted < total) ? beats[accepted] : {$urandom, $urandom};
                @(negedge clk);
                sample_writes();
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (ld_abort) abort_cyc = cyc;
                if (s_valid && s_ready && !ld_abort) accepted++;
                if (s_ready) vidx++;
                if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                    chk("idle_after_done", {63'd0, idle}, 64'd1);
                    finished = 1;
                end
                if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                    chk("idle_after_abort", {63'd0, idle}, 64'd1);
                    finished = 1;
                end
                @(posedge clk); #1;
            end
        end
        ld_conf = 1'b0; ld_abort = 1'b0; s_valid = 1'b0;

        if (!finished) chk("timeout", 64'd0, 64'd1);
        chk("n_writes", 64'(n_wr), 64'(n_exp));
        if (reset_at == 0) chk("done_pulses", 64'(done_cnt), (abort_at > 0) ? 64'd0 : 64'd1);
        if (abort_at == 0 && reset_at == 0) begin
            if (groups > 0) chk("done_latency",  64'(done_cyc - last_wr_cyc), 64'd1);
            else            chk("done_latency0", 64'(done_cyc - conf_cyc),    64'd2);
        end
        $display("load start=%0d groups=%0d vmode=%0d abort_at=%0d reset_at=%0d writes=%0d",
                 start, groups, vmode, abort_at, reset_at, n_wr);
    endtask

    initial begin
        rst_n = 1'b0; ld_conf = 1'b0; st_wr_addr = '0; ld_groups = '0;
        ld_abort = 1'b0; s_data = '0; s_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset_wr_en",   {62'd0, wr_en},   64'd0);
        chk("reset_data_wr", data_wr,          64'd0);
        chk("reset_wr_addr", {55'd0, wr_addr}, 64'd0);
        chk("reset_done",    {63'd0, done},    64'd0);
        chk("reset_s_ready", {63'd0, s_ready}, 64'd0);
        chk("reset_idle",    {63'd0, idle},    64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_load(5,   3, 0, 1, 0, 0);
        run_load(511, 2, 0, 0, 0, 0);
        run_load(40,  2, 2, 0, 0, 0);
        run_load(7,   0, 0, 0, 0, 0);
        run_load(30,  2, 0, 0, 0, 3);
        run_load(9,   1, 0, 0, 0, 0);
        run_load(20,  2, 0, 0, 1, 0);

        // Abort and start in the same idle cycle: abort wins, nothing starts.
        ld_abort = 1'b1; ld_conf = 1'b1; st_wr_addr = 9'd3; ld_groups = 10'd1;
        @(posedge clk); #1;
        ld_abort = 1'b0; ld_conf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_conf_idle",  {63'd0, idle},    64'd1);
            chk("abort_conf_ready", {63'd0, s_ready}, 64'd0);
            chk("abort_conf_wr_en", {62'd0, wr_en},   64'd0);
        end
        @(posedge clk); #1;
        $display("abort+conf in idle: stayed idle");

        run_load(100, 1, 0, 2, 0, 0);
        for (int t = 0; t < 10; t++) begin
            run_load(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 6)), 1, 0, 0, 0);
        end
        run_load(int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
